// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit and the forwarding unit:
// FSM encodings, forward-select bit indices and the shadow-entry layout.
package hazard_control_unit_pkg;

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_DIV_BUSY = 1'b1
  } hcu_state_t;

  localparam int FWD_OP1     = 0;
  localparam int FWD_OP2     = 1;
  localparam int SHADOW_RD_W = 5;

  typedef struct packed {
    logic                   valid;
    logic [SHADOW_RD_W-1:0] rd;
    logic                   regwrite;
    logic                   memread;
    logic                   div;
  } shadow_entry_t;

  localparam shadow_entry_t SHADOW_EMPTY = '{
    valid:    1'b0,
    rd:       {SHADOW_RD_W{1'b0}},
    regwrite: 1'b0,
    memread:  1'b0,
    div:      1'b0
  };

  function automatic shadow_entry_t make_entry(
    input logic                   valid,
    input logic [SHADOW_RD_W-1:0] rd,
    input logic                   regwrite,
    input logic                   memread,
    input logic                   div
  );
    shadow_entry_t e;
    e.valid    = valid;
    e.rd       = rd;
    e.regwrite = regwrite;
    e.memread  = memread;
    e.div      = div;
    return e;
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// ID-stage decode fields in, stall/bubble and forwarding selects out.
interface hazard_control_unit_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rs1_addr;
  logic [REG_ADDR_W-1:0] id_rs2_addr;
  logic [REG_ADDR_W-1:0] id_rd_addr;
  logic                  id_reg_write_en;
  logic                  id_mem_read;
  logic                  id_div_op;
  logic                  flush;
  logic                  stall;
  logic                  ex_hold;
  logic                  bubble;
  logic [1:0]            mem_forward_en;
  logic [1:0]            wb_forward_en;
  logic                  div_busy;

  modport master (
    output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_reg_write_en, id_mem_read, id_div_op, flush,
    input  stall, ex_hold, bubble, mem_forward_en, wb_forward_en, div_busy
  );

  modport slave (
    input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr,
           id_reg_write_en, id_mem_read, id_div_op, flush,
    output stall, ex_hold, bubble, mem_forward_en, wb_forward_en, div_busy
  );
endinterface

// File: rtl/hazard_control_unit_shadow_entry.sv
// Match comparator: a shadow entry supplies a source operand when it is a
// valid, register-writing instruction whose non-x0 rd equals rs.
module hazard_control_unit_shadow_entry #(
  parameter int ADDR_W = 5
) (
  input  logic              valid,
  input  logic              regwrite,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs,
  output logic              match
);

  assign match = valid && regwrite && (rd != {ADDR_W{1'b0}}) && (rd == rs);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard sequencer: tracks EX/MEM destination shadows, produces
// registered forwarding selects, load-use stall, flush bubble and divide hold.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  hazard_control_unit_if.slave  hz
);

  localparam int              CNT_W     = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam logic            DIV_ENTER = (DIV_CYCLES > 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  hcu_state_t        state_r;
  logic [CNT_W-1:0]  div_cnt_r;
  shadow_entry_t     ex_r;
  shadow_entry_t     mem_r;
  logic [1:0]        mem_fwd_r;
  logic [1:0]        wb_fwd_r;

  logic [REG_ADDR_W-1:0] rs_s [2];
  logic [1:0]            ex_match_s;
  logic [1:0]            mem_match_s;
  logic                  load_use_s;
  logic                  stall_s;
  logic                  ex_hold_s;
  logic                  bubble_s;
  logic                  unused_fields_s;

  assign rs_s[FWD_OP1] = hz.id_rs1_addr;
  assign rs_s[FWD_OP2] = hz.id_rs2_addr;

  for (genvar op = 0; op < 2; op++) begin : g_match
    hazard_control_unit_shadow_entry #(.ADDR_W(REG_ADDR_W)) u_ex_cmp (
      .valid    (ex_r.valid),
      .regwrite (ex_r.regwrite),
      .rd       (ex_r.rd),
      .rs       (rs_s[op]),
      .match    (ex_match_s[op])
    );
    hazard_control_unit_shadow_entry #(.ADDR_W(REG_ADDR_W)) u_mem_cmp (
      .valid    (mem_r.valid),
      .regwrite (mem_r.regwrite),
      .rd       (mem_r.rd),
      .rs       (rs_s[op]),
      .match    (mem_match_s[op])
    );
  end

  assign load_use_s = (state_r == ST_RUN) && hz.id_valid && !hz.flush &&
                      ex_r.memread && (|ex_match_s);

  // Pipeline-register hold/bubble controls for the current cycle.
  always_comb begin
    stall_s   = 1'b0;
    ex_hold_s = 1'b0;
    bubble_s  = 1'b0;
    if (reset) begin
      stall_s   = 1'b0;
      ex_hold_s = 1'b0;
      bubble_s  = 1'b0;
    end else if (state_r == ST_DIV_BUSY) begin
      stall_s   = 1'b1;
      ex_hold_s = 1'b1;
      bubble_s  = 1'b1;
    end else if (hz.flush) begin
      bubble_s  = 1'b1;
    end else if (load_use_s) begin
      stall_s   = 1'b1;
      bubble_s  = 1'b1;
    end else begin
      stall_s   = 1'b0;
    end
  end

  // Sequencer state, shadow entries and registered forwarding selects.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_RUN;
      div_cnt_r <= CNT_ZERO;
      ex_r      <= SHADOW_EMPTY;
      mem_r     <= SHADOW_EMPTY;
      mem_fwd_r <= 2'b00;
      wb_fwd_r  <= 2'b00;
    end else begin
      case (state_r)
        ST_RUN: begin
          mem_r <= ex_r;
          if (hz.flush || load_use_s) begin
            ex_r      <= SHADOW_EMPTY;
            mem_fwd_r <= 2'b00;
            wb_fwd_r  <= 2'b00;
          end else begin
            ex_r      <= make_entry(hz.id_valid, hz.id_rd_addr, hz.id_reg_write_en,
                                    hz.id_mem_read, hz.id_div_op);
            mem_fwd_r <= ex_match_s;
            // MEM has priority so an operand never selects both sources.
            wb_fwd_r  <= mem_match_s & ~ex_match_s;
            if (DIV_ENTER && hz.id_valid && hz.id_div_op) begin
              state_r   <= ST_DIV_BUSY;
              div_cnt_r <= DIV_LOAD;
            end
          end
        end
        ST_DIV_BUSY: begin
          mem_r     <= SHADOW_EMPTY;
          mem_fwd_r <= 2'b00;
          wb_fwd_r  <= 2'b00;
          div_cnt_r <= div_cnt_r - CNT_ONE;
          if (div_cnt_r == CNT_ONE) begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r   <= ST_RUN;
          div_cnt_r <= CNT_ZERO;
          ex_r      <= SHADOW_EMPTY;
          mem_r     <= SHADOW_EMPTY;
          mem_fwd_r <= 2'b00;
          wb_fwd_r  <= 2'b00;
        end
      endcase
    end
  end

  // Shadow fields kept for the forwarding unit's view but not needed here.
  assign unused_fields_s = ^{ex_r.div, mem_r.memread, mem_r.div};

  assign hz.stall          = stall_s;
  assign hz.ex_hold        = ex_hold_s;
  assign hz.bubble         = bubble_s;
  assign hz.mem_forward_en = mem_fwd_r;
  assign hz.wb_forward_en  = wb_fwd_r;
  assign hz.div_busy       = (state_r == ST_DIV_BUSY);

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed vector bench for hazard_control_unit with DIV_CYCLES = 4.
module tb_hazard_control_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_control_unit_if #(.REG_ADDR_W(5)) hz ();

  hazard_control_unit #(.DIV_CYCLES(4), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  typedef struct {
    logic       rst;
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       we;
    logic       mr;
    logic       dv;
    logic       fl;
    logic [7:0] exp; // {stall, ex_hold, bubble, mem_fwd[1:0], wb_fwd[1:0], div_busy}
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  task automatic add(input int rst, input int v, input int rs1, input int rs2, input int rd,
                     input int we, input int mr, input int dv, input int fl,
                     input int st, input int eh, input int bb, input int mf, input int wf,
                     input int db);
    vec_t t;
    t.rst = 1'(rst); t.v = 1'(v);
    t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd);
    t.we = 1'(we); t.mr = 1'(mr); t.dv = 1'(dv); t.fl = 1'(fl);
    t.exp = {1'(st), 1'(eh), 1'(bb), 2'(mf), 2'(wf), 1'(db)};
    vecs.push_back(t);
  endtask

  task automatic drive(input logic rst, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic mr, input logic dv,
                       input logic fl);
    reset              = rst;
    hz.id_valid        = v;
    hz.id_rs1_addr     = rs1;
    hz.id_rs2_addr     = rs2;
    hz.id_rd_addr      = rd;
    hz.id_reg_write_en = we;
    hz.id_mem_read     = mr;
    hz.id_div_op       = dv;
    hz.flush           = fl;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, want);
    end
  endtask

  function automatic logic [7:0] sample();
    return {hz.stall, hz.ex_hold, hz.bubble, hz.mem_forward_en, hz.wb_forward_en, hz.div_busy};
  endfunction

  initial begin
    // mf/wf columns: 1 = operand 1 (bit0), 2 = operand 2 (bit1), 3 = both
    //   rst v rs1 rs2 rd we mr dv fl | st eh bb mf wf db
    add(1, 0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 0 reset state
    add(0, 1,  1,  2,  5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 1 add x5
    add(0, 1,  5,  7,  6, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 2 sub x6,x5,x7
    add(0, 1,  1,  2,  9, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0); // 3 sub sees MEM fwd op1
    add(0, 1,  0,  0,  5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 4 producer x5
    add(0, 1,  1,  2, 10, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 5 unrelated
    add(0, 1,  3,  5, 11, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 6 consumer rs2=x5
    add(0, 1,  0,  0,  5, 1, 0, 0, 0,   0, 0, 0, 0, 2, 0); // 7 WB fwd op2; producer x5
    add(0, 1,  1,  2,  5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 8 second producer x5
    add(0, 1,  4,  5, 12, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 9 consumer rs2=x5
    add(0, 1,  2,  0,  8, 1, 1, 0, 0,   0, 0, 0, 2, 0, 0); // 10 MEM wins; lw x8
    add(0, 1,  8,  8, 13, 1, 0, 0, 0,   1, 0, 1, 0, 0, 0); // 11 load-use stall
    add(0, 1,  8,  8, 13, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 12 retry
    add(0, 1,  1,  2,  0, 1, 1, 0, 0,   0, 0, 0, 0, 3, 0); // 13 WB fwd both; lw x0
    add(0, 1,  0,  0, 14, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 14 rs=x0 vs load x0: nothing
    add(0, 1,  1,  0,  8, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0); // 15 lw x8
    add(0, 1,  8,  3, 15, 1, 0, 0, 1,   0, 0, 1, 0, 0, 0); // 16 load-use + FLUSH
    add(0, 1,  8,  0, 15, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 17 selects 00 after flush
    add(0, 1,  0,  0, 20, 1, 1, 0, 0,   0, 0, 0, 0, 1, 0); // 18 lw x20
    add(0, 1, 20,  2, 21, 1, 0, 1, 0,   1, 0, 1, 0, 0, 0); // 19 div on load: load-use wins
    add(0, 1, 20,  2, 21, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0); // 20 div enters EX
    add(0, 1, 21,  0, 22, 1, 0, 0, 0,   1, 1, 1, 0, 1, 1); // 21 busy 1, div's own selects
    add(0, 1, 21,  0, 22, 1, 0, 0, 0,   1, 1, 1, 0, 0, 1); // 22 busy 2
    add(0, 1, 21,  0, 22, 1, 0, 0, 0,   1, 1, 1, 0, 0, 1); // 23 busy 3
    add(0, 1, 21,  0, 22, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 24 RUN, div completes
    add(0, 0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0); // 25 consumer got MEM fwd
    add(0, 1,  0,  0, 23, 1, 0, 1, 1,   0, 0, 1, 0, 0, 0); // 26 FLUSH kills div
    add(0, 0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 27 no DIV_BUSY
    add(0, 1,  1,  2, 24, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0); // 28 div enters EX
    add(0, 0,  0,  0,  0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 1); // 29 busy 1
    add(1, 0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1); // 30 reset in busy 2
    add(0, 1,  0,  0,  5, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 31 aborted; add x5
    add(0, 1,  5,  5,  6, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0); // 32 consumer x5,x5
    add(0, 0,  0,  0,  0, 0, 0, 0, 0,   0, 0, 0, 3, 0, 0); // 33 MEM fwd both

    drive(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd,
            vecs[i].we, vecs[i].mr, vecs[i].dv, vecs[i].fl);
      #1;
      check($sformatf("row%0d", i), sample(), vecs[i].exp);
    end

    // Divide hold length measured with a bounded wait on DIV_BUSY.
    begin
      int busy_cycles;
      busy_cycles = 0;
      @(negedge clk);
      drive(1'b0, 1'b1, 5'd1, 5'd2, 5'd26, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      check("div_issue", sample(), 8'b000_00_00_0);
      @(negedge clk);
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 0; c < 20; c++) begin
        #1;
        if (hz.div_busy) begin
          busy_cycles++;
          check($sformatf("div_hold%0d", busy_cycles), sample(), 8'b111_00_00_1);
        end else begin
          break;
        end
        @(negedge clk);
      end
      check("div_busy_len", 8'(busy_cycles), 8'd3);
      check("div_exit", sample(), 8'b000_00_00_0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
